// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and default vectors for the PC sequencer
package pc_pkg;
    typedef enum logic {SEQ, SLOT} pc_state_t;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;
    localparam int          PC_ALIGN_BITS   = 2;
endpackage

// File: rtl/pc_incr.sv
// pc_incr: sequential next-PC adder, wraps modulo 2^WIDTH
module pc_incr #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] sum
);
    assign sum = pc + WIDTH'(INC);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with branch/jump/exception redirects and optional delay slot
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter int               DELAY_SLOT   = 1,
    parameter int               ALIGN_BITS   = PC_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             in_slot,
    output logic             addr_err,
    output logic             slot_err
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    pc_state_t        state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] raw_target;
    logic             req;
    pc_incr #(.WIDTH(WIDTH), .INC(INC)) u_incr (.pc(pc), .sum(pc_next_seq));
    assign req        = jump | br_taken;
    assign raw_target = jump ? jump_target : br_target;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            pending  <= '0;
            state    <= SEQ;
            in_slot  <= 1'b0;
            addr_err <= 1'b0;
            slot_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            slot_err <= 1'b0;
            if (exc) begin
                pc      <= EXC_VECTOR;
                state   <= SEQ;
                in_slot <= 1'b0;
            end else if (!stall) begin
                // a request seen during the slot fetch is dropped, not queued
                if (DELAY_SLOT != 0 && state == SLOT) begin
                    pc       <= pending;
                    state    <= SEQ;
                    in_slot  <= 1'b0;
                    slot_err <= req;
                end else if (req) begin
                    addr_err <= |(raw_target & ALIGN_MASK);
                    if (DELAY_SLOT != 0) begin
                        pending <= raw_target & ~ALIGN_MASK;
                        pc      <= pc_next_seq;
                        in_slot <= 1'b1;
                        state   <= SLOT;
                    end else begin
                        pc <= raw_target & ~ALIGN_MASK;
                    end
                end else begin
                    pc <= pc_next_seq;
                end
            end
        end
    end
endmodule
